// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C GPIO-expander target and its helpers.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StCmd,
    StCmdAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } i2c_state_e;

  localparam logic [2:0] REG_IN0  = 3'd0;
  localparam logic [2:0] REG_IN1  = 3'd1;
  localparam logic [2:0] REG_OUT0 = 3'd2;
  localparam logic [2:0] REG_OUT1 = 3'd3;
  localparam logic [2:0] REG_POL0 = 3'd4;
  localparam logic [2:0] REG_POL1 = 3'd5;
  localparam logic [2:0] REG_CFG0 = 3'd6;
  localparam logic [2:0] REG_CFG1 = 3'd7;

  localparam logic [6:0] DEF_ADDR = 7'h74;

  localparam logic [7:0] RST_IN  = 8'h00;
  localparam logic [7:0] RST_OUT = 8'hFF;
  localparam logic [7:0] RST_POL = 8'h00;
  localparam logic [7:0] RST_CFG = 8'hFF;

  function automatic logic [7:0] reg_rst_val(input logic [2:0] idx);
    unique case (idx)
      REG_IN0, REG_IN1:   return RST_IN;
      REG_OUT0, REG_OUT1: return RST_OUT;
      REG_POL0, REG_POL1: return RST_POL;
      default:            return RST_CFG;
    endcase
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with edge and START/STOP pulse generation.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_hist;
  logic                   r_sda_hist;
  logic                   w_scl;
  logic                   w_scl_high;

  // Flops reset to 1 so an idle (pulled-up) bus produces no spurious edges.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_hist <= w_scl;
      r_sda_hist <= o_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign o_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_high = w_scl & r_scl_hist;
  assign o_scl_rise = w_scl & ~r_scl_hist;
  assign o_scl_fall = ~w_scl & r_scl_hist;
  assign o_start    = w_scl_high & r_sda_hist & ~o_sda;
  assign o_stop     = w_scl_high & ~r_sda_hist & o_sda;

endmodule

// File: rtl/i2c_gpio_target.sv
// I2C target emulating a 16-bit GPIO expander: 8 byte registers, pointer-based
// writes with pair alternation, and reads with input-polarity inversion.
module i2c_gpio_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR  = DEF_ADDR,
  parameter int unsigned SDA_HOLD_CYC = 3,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        s_clk_25mhz,
  input  logic        s_rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out,
  output logic [15:0] gpio_oe,
  output logic        busy,
  output logic        wr_strobe,
  output logic [2:0]  wr_addr,
  output logic [7:0]  wr_data
);

  localparam int unsigned HW = $clog2(SDA_HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(SDA_HOLD_CYC);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk     (s_clk_25mhz),
    .i_rst     (s_rst),
    .i_scl     (scl_in),
    .i_sda     (sda_in),
    .o_sda     (w_sda),
    .o_scl_rise(w_scl_rise),
    .o_scl_fall(w_scl_fall),
    .o_start   (w_start),
    .o_stop    (w_stop)
  );

  i2c_state_e     r_state, w_state_nxt;
  logic [7:0]     r_shift, w_shift_nxt;
  logic [2:0]     r_bitcnt, w_bitcnt_nxt;
  logic [2:0]     r_ptr, w_ptr_nxt;
  logic           r_ack_hi, w_ack_hi_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_oe, w_oe_nxt;
  logic           r_oe_pend, w_oe_pend_nxt;
  logic [HW-1:0]  r_hold, w_hold_nxt;
  logic           w_we;
  logic [7:0]     r_regs [8];
  logic [15:0]    r_gpio_in;
  logic           r_strobe;
  logic [2:0]     r_waddr;
  logic [7:0]     r_wdata;
  logic [7:0]     w_byte;
  logic [7:0]     w_rd_byte;

  assign w_byte = {r_shift[6:0], w_sda};

  always_comb begin
    unique case (r_ptr)
      REG_IN0: w_rd_byte = r_gpio_in[7:0] ^ r_regs[REG_POL0];
      REG_IN1: w_rd_byte = r_gpio_in[15:8] ^ r_regs[REG_POL1];
      default: w_rd_byte = r_regs[r_ptr];
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bitcnt_nxt  = r_bitcnt;
    w_ptr_nxt     = r_ptr;
    w_ack_hi_nxt  = r_ack_hi;
    w_busy_nxt    = r_busy;
    w_oe_nxt      = r_oe;
    w_oe_pend_nxt = r_oe_pend;
    w_hold_nxt    = r_hold;
    w_we          = 1'b0;

    // SDA updates are deferred by the hold countdown armed on each SCL fall.
    if (r_hold != '0) begin
      w_hold_nxt = r_hold - HW'(1);
      if (r_hold == HW'(1)) w_oe_nxt = r_oe_pend;
    end

    unique case (r_state)
      StAddr, StCmd, StWdata: begin
        if (w_scl_rise) begin
          w_shift_nxt  = w_byte;
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            w_ack_hi_nxt = 1'b0;
            if (r_state == StAddr) begin
              w_state_nxt = (w_byte[7:1] == TARGET_ADDR) ? StAddrAck : StIgnore;
            end else if (r_state == StCmd) begin
              if (w_byte[7:3] == 5'd0) begin
                w_ptr_nxt   = w_byte[2:0];
                w_state_nxt = StCmdAck;
              end else begin
                w_state_nxt = StIgnore;
              end
            end else begin
              w_state_nxt = StWdataAck;
            end
          end
        end
      end
      StAddrAck, StCmdAck, StWdataAck: begin
        if (w_scl_rise) w_ack_hi_nxt = 1'b1;
        if (w_scl_fall) begin
          w_hold_nxt = HOLD_INIT;
          if (!r_ack_hi) begin
            w_oe_pend_nxt = 1'b1;
          end else begin
            w_bitcnt_nxt  = 3'd0;
            w_oe_pend_nxt = 1'b0;
            if (r_state == StAddrAck && r_shift[0]) begin
              w_shift_nxt   = w_rd_byte;
              w_oe_pend_nxt = ~w_rd_byte[7];
              w_state_nxt   = StRdata;
            end else if (r_state == StAddrAck) begin
              w_state_nxt = StCmd;
            end else begin
              // Input registers are read-only: ACKed but never stored.
              w_we         = (r_state == StWdataAck) && (r_ptr[2:1] != 2'b00);
              w_ptr_nxt[0] = (r_state == StWdataAck) ? ~r_ptr[0] : r_ptr[0];
              w_state_nxt  = StWdata;
            end
          end
        end
      end
      StRdata: begin
        if (w_scl_rise) begin
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            w_ack_hi_nxt = 1'b0;
            w_state_nxt  = StRdataAck;
          end
        end
        if (w_scl_fall) begin
          w_shift_nxt   = {r_shift[6:0], 1'b0};
          w_oe_pend_nxt = ~r_shift[6];
          w_hold_nxt    = HOLD_INIT;
        end
      end
      StRdataAck: begin
        if (w_scl_rise) begin
          if (w_sda) begin
            w_state_nxt = StIgnore;
          end else begin
            w_ptr_nxt[0] = ~r_ptr[0];
            w_ack_hi_nxt = 1'b1;
          end
        end
        if (w_scl_fall) begin
          w_hold_nxt = HOLD_INIT;
          if (!r_ack_hi) begin
            w_oe_pend_nxt = 1'b0;
          end else begin
            w_shift_nxt   = w_rd_byte;
            w_oe_pend_nxt = ~w_rd_byte[7];
            w_bitcnt_nxt  = 3'd0;
            w_state_nxt   = StRdata;
          end
        end
      end
      default: ;
    endcase

    if (w_start || w_stop) begin
      w_state_nxt  = w_start ? StAddr : StIdle;
      w_busy_nxt   = w_start;
      w_bitcnt_nxt = 3'd0;
      w_ack_hi_nxt = 1'b0;
      w_oe_nxt     = 1'b0;
      w_hold_nxt   = '0;
      w_we         = 1'b0;
    end
  end

  always_ff @(posedge s_clk_25mhz) begin
    if (s_rst) begin
      r_state   <= StIdle;
      r_shift   <= 8'h00;
      r_bitcnt  <= 3'd0;
      r_ptr     <= 3'd0;
      r_ack_hi  <= 1'b0;
      r_busy    <= 1'b0;
      r_oe      <= 1'b0;
      r_oe_pend <= 1'b0;
      r_hold    <= '0;
      r_gpio_in <= 16'h0000;
      r_strobe  <= 1'b0;
      r_waddr   <= 3'd0;
      r_wdata   <= 8'h00;
      for (int i = 0; i < 8; i++) r_regs[i] <= reg_rst_val(3'(i));
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_ack_hi  <= w_ack_hi_nxt;
      r_busy    <= w_busy_nxt;
      r_oe      <= w_oe_nxt;
      r_oe_pend <= w_oe_pend_nxt;
      r_hold    <= w_hold_nxt;
      r_gpio_in <= gpio_in;
      r_strobe  <= w_we;
      if (w_we) begin
        r_regs[r_ptr] <= r_shift;
        r_waddr       <= r_ptr;
        r_wdata       <= r_shift;
      end
    end
  end

  assign sda_oe    = r_oe;
  assign busy      = r_busy;
  assign wr_strobe = r_strobe;
  assign wr_addr   = r_waddr;
  assign wr_data   = r_wdata;
  assign gpio_out  = {r_regs[REG_OUT1], r_regs[REG_OUT0]};
  assign gpio_oe   = ~{r_regs[REG_CFG1], r_regs[REG_CFG0]};

endmodule

// File: tb/tb_i2c_gpio_target.sv
// Bench for i2c_gpio_target: bit-banged I2C master plus a register-map model.
module tb_i2c_gpio_target;

  logic        clk = 1'b0;
  logic        s_rst = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_oe;
  logic [15:0] tb_gpio_in = 16'h0000;
  logic [15:0] gpio_out, gpio_oe;
  logic        busy, wr_strobe;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        w_bus_sda;

  assign w_bus_sda = m_sda & ~sda_oe;

  always #20 clk = ~clk;

  i2c_gpio_target dut (
    .s_clk_25mhz(clk),
    .s_rst      (s_rst),
    .scl_in     (m_scl),
    .sda_in     (w_bus_sda),
    .sda_oe     (sda_oe),
    .gpio_in    (tb_gpio_in),
    .gpio_out   (gpio_out),
    .gpio_oe    (gpio_oe),
    .busy       (busy),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          n_strobe_tot = 0;
  int          n_oe_cyc = 0;
  logic [10:0] q_obs[$];
  logic [10:0] q_exp[$];
  logic [7:0]  m_regs[8];
  logic [2:0]  m_ptr;
  logic [7:0]  wbuf[8];

  always @(negedge clk) begin
    if (wr_strobe) begin
      q_obs.push_back({wr_addr, wr_data});
      n_strobe_tot++;
    end
    if (sda_oe) n_oe_cyc++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 4 || i == 5 || i < 2) m_regs[i] = 8'h00;
      else m_regs[i] = 8'hFF;
    end
    m_ptr = 3'd0;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    tick(10);
    m_scl = 1'b1;
    tick(10);
    m_sda = 1'b0;
    tick(10);
    m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    m_scl = 1'b0;
    tick(3);
    m_sda = 1'b0;
    tick(7);
    m_scl = 1'b1;
    tick(10);
    m_sda = 1'b1;
    tick(10);
  endtask

  // One SCL clock: master drives b in the low phase, returns bus level mid-high.
  task automatic bit_clk(input logic b, output logic obs);
    tick(3);
    m_sda = b;
    tick(7);
    m_scl = 1'b1;
    tick(5);
    obs = w_bus_sda;
    tick(5);
    m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic obs;
    for (int i = 7; i >= 0; i--) bit_clk(b[i], obs);
    bit_clk(1'b1, obs);
    ack = ~obs;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic obs;
    for (int i = 7; i >= 0; i--) begin
      bit_clk(1'b1, obs);
      b[i] = obs;
    end
    bit_clk(nack, obs);
  endtask

  task automatic check_strobes();
    chk("strobe_cnt", 16'(q_obs.size()), 16'(q_exp.size()));
    for (int i = 0; i < q_obs.size() && i < q_exp.size(); i++)
      chk("strobe", 16'(q_obs[i]), 16'(q_exp[i]));
    q_obs.delete();
    q_exp.delete();
  endtask

  task automatic check_pins();
    chk("gpio_out", gpio_out, {m_regs[3], m_regs[2]});
    chk("gpio_oe", gpio_oe, ~{m_regs[7], m_regs[6]});
  endtask

  task automatic wr_txn(input logic [7:0] cmd, input int n);
    logic ack;
    logic cvalid;
    cvalid = (cmd[7:3] == 5'd0);
    i2c_start();
    chk("busy_start", 16'(busy), 16'd1);
    send_byte(8'hE8, ack);
    chk("addr_ack", 16'(ack), 16'd1);
    send_byte(cmd, ack);
    chk("cmd_ack", 16'(ack), 16'(cvalid));
    if (cvalid) m_ptr = cmd[2:0];
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ack);
      chk("data_ack", 16'(ack), 16'(cvalid));
      if (cvalid) begin
        if (m_ptr >= 3'd2) begin
          m_regs[m_ptr] = wbuf[i];
          q_exp.push_back({m_ptr, wbuf[i]});
        end
        m_ptr[0] = ~m_ptr[0];
      end
    end
    i2c_stop();
    chk("busy_stop", 16'(busy), 16'd0);
    check_strobes();
    check_pins();
  endtask

  task automatic rd_txn(input logic [2:0] ptr, input int n);
    logic       ack;
    logic [7:0] b;
    logic [7:0] exp;
    i2c_start();
    send_byte(8'hE8, ack);
    chk("rd_addr_w_ack", 16'(ack), 16'd1);
    send_byte({5'd0, ptr}, ack);
    chk("rd_cmd_ack", 16'(ack), 16'd1);
    m_ptr = ptr;
    i2c_start();
    send_byte(8'hE9, ack);
    chk("rd_addr_r_ack", 16'(ack), 16'd1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, b);
      if (m_ptr == 3'd0) exp = tb_gpio_in[7:0] ^ m_regs[4];
      else if (m_ptr == 3'd1) exp = tb_gpio_in[15:8] ^ m_regs[5];
      else exp = m_regs[m_ptr];
      chk("rd_byte", 16'(b), 16'(exp));
      if (i != n - 1) m_ptr[0] = ~m_ptr[0];
    end
    tick(8);
    chk("rd_release", 16'(sda_oe), 16'd0);
    i2c_stop();
    check_strobes();
  endtask

  initial begin
    logic ack;
    logic obs;
    int   base;
    logic [7:0] cmd;
    int   n;

    model_reset();
    tick(4);
    s_rst = 1'b0;
    tick(2);
    chk("rst_sda_oe", 16'(sda_oe), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_wr_strobe", 16'(wr_strobe), 16'd0);
    chk("rst_wr_addr", 16'(wr_addr), 16'd0);
    chk("rst_wr_data", 16'(wr_data), 16'd0);
    chk("rst_gpio_out", gpio_out, 16'hFFFF);
    chk("rst_gpio_oe", gpio_oe, 16'h0000);

    // Config low byte to outputs, then the rest of the four-write sequence.
    base = n_strobe_tot;
    wbuf[0] = 8'h00;
    wr_txn(8'h06, 1);
    chk("cfg0_oe", gpio_oe, 16'h00FF);
    wbuf[0] = 8'hA5;
    wr_txn(8'h02, 1);
    wbuf[0] = 8'h00;
    wr_txn(8'h07, 1);
    wbuf[0] = 8'h3C;
    wr_txn(8'h03, 1);
    chk("seq_gpio_out", gpio_out, 16'h3CA5);
    chk("seq_gpio_oe", gpio_oe, 16'hFFFF);
    chk("seq_strobes", 16'(n_strobe_tot - base), 16'd4);

    // Foreign address: never driven, still busy until STOP.
    base = n_oe_cyc;
    i2c_start();
    send_byte(8'hEA, ack);
    chk("foreign_ack", 16'(ack), 16'd0);
    send_byte(8'h02, ack);
    chk("foreign_cmd_ack", 16'(ack), 16'd0);
    send_byte(8'h55, ack);
    chk("foreign_busy", 16'(busy), 16'd1);
    i2c_stop();
    chk("foreign_busy_stop", 16'(busy), 16'd0);
    chk("foreign_oe_cyc", 16'(n_oe_cyc - base), 16'd0);
    check_strobes();
    check_pins();
    wbuf[0] = 8'h5A;
    wr_txn(8'h02, 1);

    // Loopback read with polarity 0.
    tb_gpio_in = 16'h1234;
    tick(2);
    i2c_start();
    send_byte(8'hE8, ack);
    send_byte(8'h00, ack);
    m_ptr = 3'd0;
    rd_txn(3'd0, 2);

    // STOP mid-byte in WDATA discards the partial byte.
    i2c_start();
    send_byte(8'hE8, ack);
    send_byte(8'h02, ack);
    for (int i = 0; i < 4; i++) bit_clk(1'b0, obs);
    i2c_stop();
    tick(2);
    chk("partial_sda_oe", 16'(sda_oe), 16'd0);
    chk("partial_busy", 16'(busy), 16'd0);
    check_strobes();
    check_pins();

    // Reset while the address ACK is being driven.
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_clk(1'(8'hE8 >> i), obs);
    tick(3);
    m_sda = 1'b1;
    tick(7);
    chk("ack_drive", 16'(sda_oe), 16'd1);
    s_rst = 1'b1;
    tick(1);
    s_rst = 1'b0;
    chk("rst_mid_sda_oe", 16'(sda_oe), 16'd0);
    chk("rst_mid_busy", 16'(busy), 16'd0);
    model_reset();
    m_scl = 1'b1;
    tick(10);
    i2c_stop();
    check_strobes();
    check_pins();

    // Bad command byte: NACK and following data ignored.
    wbuf[0] = 8'h77;
    wr_txn(8'h08, 1);

    // Randomized writes and read-backs against the model.
    for (int t = 0; t < 8; t++) begin
      cmd = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) cmd = 8'h08 | 8'($urandom_range(0, 247));
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      wr_txn(cmd, n);
      tb_gpio_in = 16'($urandom);
      tick(2);
      rd_txn(3'($urandom_range(0, 7)), int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_gpio_target.md
Name: i2c_gpio_target

Overview:
- I2C target (slave) that emulates the ROIC board's 16-bit GPIO expander: 7-bit address 0x74, 8 byte registers (input/output/polarity/config pairs).
- Receives the configuration writes issued by the I2C master: cmd 0x06/0x07 set config, cmd 0x02/0x03 set gate GPIO outputs.
- Also services reads, so the FPGA can close the loop in loopback, and serves as the bench model for master regressions.
- Oversamples SCL/SDA on the 25 MHz system clock; drives SDA open-drain.

Parameters:
- TARGET_ADDR, 7'h74, 7-bit address matched (write byte 0xE8, read byte 0xE9).
- SDA_HOLD_CYC, 3, system clocks after detected SCL fall before target changes SDA.
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in.

Ports:
- s_clk_25mhz  in  1  system clock, 25 MHz.
- s_rst  in  1  synchronous reset, active-high.
- scl_in  in  1  SCL pad input, asynchronous.
- sda_in  in  1  SDA pad input, asynchronous.
- sda_oe  out  1  1 = pull SDA low; 0 = release (pad drives 1'bz).
- gpio_in  in  16  pin levels sampled into input registers.
- gpio_out  out  16  {reg3, reg2} output-port value.
- gpio_oe  out  16  ~{reg7, reg6}; config bit 0 = output.
- busy  out  1  high from START until STOP.
- wr_strobe  out  1  one-cycle pulse per register write.
- wr_addr  out  3  register index written.
- wr_data  out  8  byte written.

Behaviour:
- Reset values:
  - sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0.
  - reg2/reg3=8'hFF, reg4/reg5=8'h00, reg6/reg7=8'hFF, so gpio_out=16'hFFFF and gpio_oe=16'h0000.
  - Pointer=0; FSM in IDLE.
- Reset mid-transaction: same values, SDA released immediately, and nothing is written.
- Input synchronization: SYNC_STAGES flops plus one history flop per line give scl_rise, scl_fall, sda_rise and sda_fall. Master period is 20 clocks (10 high / 10 low); a valid design needs at least 4 clocks per SCL phase.
- Bus conditions:
  - START = sda_fall while synced SCL is high.
  - STOP = sda_rise while SCL is high.
  - Both have priority over any bit activity in the same cycle, in every state.
  - A repeated START returns the FSM to ADDR.
  - STOP returns it to IDLE and clears busy.
  - A partial byte is discarded.
- Bit timing:
  - Data is sampled on scl_rise and shifted MSB-first into an 8-bit shift register.
  - A 3-bit count wraps after bit 7.
  - The target changes sda_oe only SDA_HOLD_CYC clocks after scl_fall.
- FSM states: IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: after 8 bits, compare [7:1] with TARGET_ADDR.
  - Match: go to ADDR_ACK and drive ACK (sda_oe=1) for the 9th clock.
  - Mismatch: go to IGNORE and never drive SDA.
- After ADDR_ACK: R/W=0 → CMD; R/W=1 → RDATA. The first read byte is loaded at the scl_fall ending the ACK.
- CMD: pointer <= byte[2:0] when byte[7:3]==0, then ACK and go to WDATA. Otherwise NACK and go to IGNORE.
- WDATA: after 8 bits, ACK, write reg[pointer] on the ACK's scl_fall, pulse wr_strobe with wr_addr/wr_data, then pointer[0] toggles (pair alternation).
  - Registers 0/1 are read-only: still ACKed, but no write and no strobe.
  - Unlimited bytes until STOP or repeated START.
- RDATA:
  - Byte source: regs 0/1 return gpio_in byte XOR polarity reg; other registers return stored values.
  - The byte is captured at load time and shifted out on each scl_fall + hold.
  - After 8 bits, release SDA and sample the master's bit on scl_rise.
  - ACK(0): pointer[0] toggles and the next byte loads.
  - NACK(1): go to IGNORE.
- IGNORE: SDA released and only START/STOP are watched.
- A STOP at any point returns the FSM to IDLE with sda_oe=0 within 1 clock of detection.

Decomposition:
- Package i2c_pkg holds:
  - the state enum typedef;
  - register index constants REG_IN0=0 … REG_CFG1=7;
  - default address 7'h74;
  - reset-value constants.
- One sub-module, i2c_bus_sync: synchronizers plus scl_rise/scl_fall/start_det/stop_det pulse generation. It is reusable by other I2C blocks.
- Register file and FSM stay in i2c_gpio_target.

Test Plan:
- Write 0xE8, 0x06, 0x00, STOP → three ACKs; one wr_strobe with wr_addr=6, wr_data=0x00; gpio_oe=16'h00FF.
- Four-transaction sequence 06/00, 02/0xA5, 07/00, 03/0x3C → gpio_out=16'h3CA5, gpio_oe=16'hFFFF, exactly 4 strobes.
- Address byte 0xEA → SDA never driven and no strobe; busy still 1 until STOP; next 0xE8 transaction is ACKed normally.
- Write 0xE8, 0x00, repeated START, 0xE9, read 2 bytes (ACK then NACK), gpio_in=16'h1234, polarity=0 → bytes 0x34, 0x12; sda_oe=0 after NACK.
- STOP after 4 data bits of WDATA, and s_rst asserted during ADDR_ACK → no register change, sda_oe=0 next clock, FSM in IDLE.
- Command byte 0x08 → NACK on 9th clock; following data byte is not ACKed or written.
